// File: rtl/riscv_v_pkg.sv
// Shared vector-CSR types: CSR select encoding, arbiter pointer and
// the select-to-enable conversion used by the write arbiter.
package riscv_v_pkg;

    localparam int RISCV_V_NUM_CSR = 6;

    typedef enum logic [2:0] {
        CSR_VSSTATUS = 3'd0,
        CSR_VTYPE    = 3'd1,
        CSR_VL       = 3'd2,
        CSR_VSTART   = 3'd3,
        CSR_VXRM     = 3'd4,
        CSR_VXSAT    = 3'd5
    } riscv_v_csr_sel_t;

    // Round-robin pointer: names the requester that wins the next collision.
    typedef enum logic {
        PTR_EXT = 1'b0,
        PTR_VEC = 1'b1
    } rr_ptr_t;

    // Encodings 6 and 7 name no CSR.
    function automatic logic csr_sel_legal(riscv_v_csr_sel_t sel);
        return (sel <= CSR_VXSAT);
    endfunction

    // One-hot write enable; an illegal select yields no enable at all.
    function automatic logic [RISCV_V_NUM_CSR-1:0] csr_onehot(riscv_v_csr_sel_t sel);
        logic [RISCV_V_NUM_CSR-1:0] oh;
        oh = '0;
        if (csr_sel_legal(sel)) begin
            oh[sel] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/riscv_v_csr_wr_arb_if.sv
// Requester-side CSR write handshake (valid/ready with select and data).
interface riscv_v_csr_wr_arb_if
    import riscv_v_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic                req_valid;
    logic                req_ready;
    riscv_v_csr_sel_t    req_sel;
    logic [DATA_W-1:0]   req_data;

    modport master (output req_valid, req_sel, req_data, input req_ready);
    modport slave  (input req_valid, req_sel, req_data, output req_ready);
endinterface

// File: rtl/riscv_v_csr_req_buf.sv
// One-entry pending register for a single CSR write requester. It can
// refill on the same edge its current entry is granted, so a requester
// sees back-to-back acceptance while the arbiter keeps up.
module riscv_v_csr_req_buf
    import riscv_v_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              grant,
    input  logic              req_valid,
    input  riscv_v_csr_sel_t  req_sel,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              pend_vld,
    output riscv_v_csr_sel_t  pend_sel,
    output logic [DATA_W-1:0] pend_data
);
    logic              pend_vld_d, pend_vld_q;
    riscv_v_csr_sel_t  pend_sel_d, pend_sel_q;
    logic [DATA_W-1:0] pend_data_d, pend_data_q;
    logic              accept;

    // Ready/accept and next entry state; flush beats both accept and grant.
    always_comb begin
        req_ready   = ~flush & (~pend_vld_q | grant);
        accept      = req_valid & req_ready;
        pend_vld_d  = pend_vld_q;
        pend_sel_d  = pend_sel_q;
        pend_data_d = pend_data_q;
        if (flush) begin
            pend_vld_d = 1'b0;
        end else if (accept) begin
            pend_vld_d  = 1'b1;
            pend_sel_d  = req_sel;
            pend_data_d = req_data;
        end else if (grant) begin
            pend_vld_d = 1'b0;
        end
    end

    // Entry valid is the only control state here; it alone needs reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld_q <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
        end
    end

    // Entry payload is plain datapath, qualified by pend_vld_q.
    always_ff @(posedge clk) begin
        pend_sel_q  <= pend_sel_d;
        pend_data_q <= pend_data_d;
    end

    assign pend_vld  = pend_vld_q;
    assign pend_sel  = pend_sel_q;
    assign pend_data = pend_data_q;

endmodule

// File: rtl/riscv_v_csr_wr_arb.sv
// Arbitrates CSR writes from the scalar core (ext) and the vector unit
// (vec) onto a single one-hot registered CSR write port. Collisions are
// resolved round-robin; illegal selects are consumed and flagged.
module riscv_v_csr_wr_arb
    import riscv_v_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       flush,
    riscv_v_csr_wr_arb_if.slave        ext,
    riscv_v_csr_wr_arb_if.slave        vec,
    output logic [RISCV_V_NUM_CSR-1:0] csr_wr_en,
    output logic [DATA_W-1:0]          csr_wr_data,
    output logic                       err_illegal_sel,
    output logic                       busy
);
    logic              ext_pend_vld, vec_pend_vld;
    riscv_v_csr_sel_t  ext_pend_sel, vec_pend_sel;
    logic [DATA_W-1:0] ext_pend_data, vec_pend_data;
    logic              grant_ext, grant_vec, grant_any, both_pend;
    riscv_v_csr_sel_t  win_sel;
    logic [DATA_W-1:0] win_data;

    rr_ptr_t                    rr_ptr_d, rr_ptr_q;
    logic [RISCV_V_NUM_CSR-1:0] csr_wr_en_d, csr_wr_en_q;
    logic [DATA_W-1:0]          csr_wr_data_d, csr_wr_data_q;
    logic                       err_d, err_q;

    riscv_v_csr_req_buf #(.DATA_W(DATA_W)) u_ext_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .grant     (grant_ext),
        .req_valid (ext.req_valid),
        .req_sel   (ext.req_sel),
        .req_data  (ext.req_data),
        .req_ready (ext.req_ready),
        .pend_vld  (ext_pend_vld),
        .pend_sel  (ext_pend_sel),
        .pend_data (ext_pend_data)
    );

    riscv_v_csr_req_buf #(.DATA_W(DATA_W)) u_vec_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .grant     (grant_vec),
        .req_valid (vec.req_valid),
        .req_sel   (vec.req_sel),
        .req_data  (vec.req_data),
        .req_ready (vec.req_ready),
        .pend_vld  (vec_pend_vld),
        .pend_sel  (vec_pend_sel),
        .pend_data (vec_pend_data)
    );

    // Grant selection: a lone entry always wins; on a collision the pointer
    // picks the winner and then moves to the loser. No grants while frozen.
    always_comb begin
        both_pend = ext_pend_vld & vec_pend_vld;
        grant_ext = ~stall & ~flush & ext_pend_vld & (~vec_pend_vld | (rr_ptr_q == PTR_EXT));
        grant_vec = ~stall & ~flush & vec_pend_vld & (~ext_pend_vld | (rr_ptr_q == PTR_VEC));
        grant_any = grant_ext | grant_vec;
        win_sel   = grant_vec ? vec_pend_sel  : ext_pend_sel;
        win_data  = grant_vec ? vec_pend_data : ext_pend_data;
        rr_ptr_d  = rr_ptr_q;
        if (both_pend && grant_ext) begin
            rr_ptr_d = PTR_VEC;
        end else if (both_pend && grant_vec) begin
            rr_ptr_d = PTR_EXT;
        end
    end

    // Output stage: enable and error are single-cycle strobes of the grant.
    always_comb begin
        csr_wr_en_d   = '0;
        err_d         = 1'b0;
        csr_wr_data_d = csr_wr_data_q;
        if (grant_any) begin
            csr_wr_data_d = win_data;
            if (csr_sel_legal(win_sel)) begin
                csr_wr_en_d = csr_onehot(win_sel);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Control state: pointer, enable and error strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= PTR_EXT;
            csr_wr_en_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            csr_wr_en_q <= csr_wr_en_d;
            err_q       <= err_d;
        end
    end

    // Write data is only meaningful alongside an enable, so it is not reset.
    always_ff @(posedge clk) begin
        csr_wr_data_q <= csr_wr_data_d;
    end

    assign csr_wr_en       = csr_wr_en_q;
    assign csr_wr_data     = csr_wr_data_q;
    assign err_illegal_sel = err_q;
    assign busy            = ext_pend_vld | vec_pend_vld | (|csr_wr_en_q);

endmodule

// File: tb/tb_riscv_v_csr_wr_arb.sv
// Bench for the vector CSR write arbiter: directed scenarios followed by a
// random phase, all compared against a transaction-level reference model.
module tb_riscv_v_csr_wr_arb;
    import riscv_v_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [5:0]  csr_wr_en;
    logic [31:0] csr_wr_data;
    logic        err_illegal_sel, busy;

    riscv_v_csr_wr_arb_if #(.DATA_W(32)) ext_if ();
    riscv_v_csr_wr_arb_if #(.DATA_W(32)) vec_if ();

    riscv_v_csr_wr_arb #(.DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .ext             (ext_if),
        .vec             (vec_if),
        .csr_wr_en       (csr_wr_en),
        .csr_wr_data     (csr_wr_data),
        .err_illegal_sel (err_illegal_sel),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: one pending slot per requester (0=ext, 1=vec),
    // the requester favoured on a collision, and the expected outputs.
    logic        m_pv [2];
    logic [2:0]  m_ps [2];
    logic [31:0] m_pd [2];
    int          m_fav;
    logic [5:0]  m_en;
    logic [31:0] m_data;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m_pv[i] = 1'b0;
        m_fav = 0;
        m_en  = '0;
        m_err = 1'b0;
    endtask

    task automatic idle();
        ext_if.req_valid = 1'b0;
        vec_if.req_valid = 1'b0;
    endtask

    task automatic req(input int who, input riscv_v_csr_sel_t sel, input logic [31:0] d);
        if (who == 0) begin
            ext_if.req_valid = 1'b1; ext_if.req_sel = sel; ext_if.req_data = d;
        end else begin
            vec_if.req_valid = 1'b1; vec_if.req_sel = sel; vec_if.req_data = d;
        end
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    // Checks ready, advances the model across the next edge, checks outputs.
    task automatic cyc();
        int          win;
        logic        rdy [2];
        logic        v [2];
        logic [2:0]  s [2];
        logic [31:0] d [2];
        logic [5:0]  en_n;
        logic        err_n;
        #1;
        v[0] = ext_if.req_valid; s[0] = ext_if.req_sel; d[0] = ext_if.req_data;
        v[1] = vec_if.req_valid; s[1] = vec_if.req_sel; d[1] = vec_if.req_data;
        win = -1;
        if (!flush && !stall) begin
            if (m_pv[0] && m_pv[1]) win = m_fav;
            else if (m_pv[0])       win = 0;
            else if (m_pv[1])       win = 1;
        end
        for (int i = 0; i < 2; i++) rdy[i] = !flush && (!m_pv[i] || win == i);
        chk("ext_ready", 32'(ext_if.req_ready), 32'(rdy[0]));
        chk("vec_ready", 32'(vec_if.req_ready), 32'(rdy[1]));
        en_n  = '0;
        err_n = 1'b0;
        if (win >= 0) begin
            if (m_ps[win] < 3'd6) begin
                en_n   = 6'd1 << m_ps[win];
                m_data = m_pd[win];
            end else begin
                err_n = 1'b1;
            end
            if (m_pv[0] && m_pv[1]) m_fav = 1 - win;
        end
        m_en  = en_n;
        m_err = err_n;
        for (int i = 0; i < 2; i++) begin
            if (flush) m_pv[i] = 1'b0;
            else if (v[i] && rdy[i]) begin
                m_pv[i] = 1'b1; m_ps[i] = s[i]; m_pd[i] = d[i];
            end else if (win == i) m_pv[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("csr_wr_en", 32'(csr_wr_en), 32'(m_en));
        chk("err_illegal_sel", 32'(err_illegal_sel), 32'(m_err));
        chk("busy", 32'(busy), 32'(m_pv[0] | m_pv[1] | (m_en != 0)));
        chk("en_onehot0", 32'($onehot0(csr_wr_en)), 32'd1);
        if (m_en != 0) chk("csr_wr_data", csr_wr_data, m_data);
    endtask

    task automatic do_reset();
        idle();
        stall = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
        #1;
        chk("rst_en", 32'(csr_wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_illegal_sel), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        ext_if.req_valid = 1'b0; ext_if.req_sel = CSR_VSSTATUS; ext_if.req_data = '0;
        vec_if.req_valid = 1'b0; vec_if.req_sel = CSR_VSSTATUS; vec_if.req_data = '0;
        #2;
        do_reset();
        #1;
        chk("rst_ext_ready", 32'(ext_if.req_ready), 32'd1);
        chk("rst_vec_ready", 32'(vec_if.req_ready), 32'd1);

        // Lone ext write to VL: enable two cycles after acceptance, one cycle wide.
        req(0, CSR_VL, 32'h10); cyc(); idle();
        chk("vl_lat1_en", 32'(csr_wr_en), 32'd0);
        cyc();
        chk("vl_en", 32'(csr_wr_en), 32'b000100);
        chk("vl_data", csr_wr_data, 32'h10);
        cyc();
        chk("vl_pulse_end", 32'(csr_wr_en), 32'd0);

        // Collision after reset: ext first, then vec; next collision vec first.
        do_reset();
        req(0, CSR_VTYPE, 32'hD1); req(1, CSR_VL, 32'h08); cyc(); idle();
        cyc();
        chk("col1_en", 32'(csr_wr_en), 32'b000010);
        chk("col1_data", csr_wr_data, 32'hD1);
        cyc();
        chk("col2_en", 32'(csr_wr_en), 32'b000100);
        chk("col2_data", csr_wr_data, 32'h08);
        cyc();
        req(0, CSR_VTYPE, 32'hA5); req(1, CSR_VL, 32'h09); cyc(); idle();
        cyc();
        chk("rcol1_en", 32'(csr_wr_en), 32'b000100);
        chk("rcol1_data", csr_wr_data, 32'h09);
        cyc();
        chk("rcol2_en", 32'(csr_wr_en), 32'b000010);
        chk("rcol2_data", csr_wr_data, 32'hA5);
        cyc();

        // Same CSR from both: serialized in grant order.
        do_reset();
        req(0, CSR_VXRM, 32'h1); req(1, CSR_VXRM, 32'h2); cyc(); idle();
        cyc();
        chk("vxrm1_en", 32'(csr_wr_en), 32'b010000);
        chk("vxrm1_data", csr_wr_data, 32'h1);
        cyc();
        chk("vxrm2_en", 32'(csr_wr_en), 32'b010000);
        chk("vxrm2_data", csr_wr_data, 32'h2);
        cyc();

        // Illegal select from vec: consumed, error pulse, no enable.
        req(1, riscv_v_csr_sel_t'(3'd7), 32'h55); cyc(); idle();
        chk("ill_err_early", 32'(err_illegal_sel), 32'd0);
        cyc();
        chk("ill_err", 32'(err_illegal_sel), 32'd1);
        chk("ill_en", 32'(csr_wr_en), 32'd0);
        cyc();
        chk("ill_err_end", 32'(err_illegal_sel), 32'd0);
        chk("ill_vec_ready", 32'(vec_if.req_ready), 32'd1);

        // Stall holds a pending VSTART write until release.
        req(0, CSR_VSTART, 32'h77); cyc(); idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_no_en", 32'(csr_wr_en), 32'd0);
        end
        stall = 1'b0;
        cyc();
        chk("stall_rel_en", 32'(csr_wr_en), 32'b001000);
        chk("stall_rel_data", csr_wr_data, 32'h77);
        cyc();

        // Flush during stall discards the pending entry.
        req(0, CSR_VSTART, 32'h33); cyc(); idle();
        stall = 1'b1; cyc();
        flush = 1'b1;
        #1;
        chk("flush_ext_ready", 32'(ext_if.req_ready), 32'd0);
        cyc();
        flush = 1'b0; stall = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("flush_no_en", 32'(csr_wr_en), 32'd0);
        end

        // Reset with both entries pending: nothing survives.
        req(0, CSR_VTYPE, 32'hBE); req(1, CSR_VXSAT, 32'h1); cyc(); idle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_no_en", 32'(csr_wr_en), 32'd0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ext_if.req_valid = ($urandom_range(0, 9) < 6);
            ext_if.req_sel   = riscv_v_csr_sel_t'(3'($urandom_range(0, 7)));
            ext_if.req_data  = $urandom;
            vec_if.req_valid = ($urandom_range(0, 9) < 6);
            vec_if.req_sel   = riscv_v_csr_sel_t'(3'($urandom_range(0, 7)));
            vec_if.req_data  = $urandom;
            stall = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 5);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
